// File: rtl/mux_io_sel_ctrl_if.sv
// mux_io_sel_ctrl_if: configuration request/ack bus between the GPIO register file and mux_io_sel_ctrl.
// Carries lock_wr/lock_mask/cfg_err only when MUX_IO_SEL_LOCK_EN is defined.
interface mux_io_sel_ctrl_if #(parameter int GPIO_WIDTH = 13);
    logic                  cfg_wr;
    logic [GPIO_WIDTH-1:0] cfg_sel;
    logic [GPIO_WIDTH-1:0] cfg_mask;
    logic                  cfg_ack;
    logic                  busy;
`ifdef MUX_IO_SEL_LOCK_EN
    logic                  lock_wr;
    logic [GPIO_WIDTH-1:0] lock_mask;
    logic                  cfg_err;
    modport master (output cfg_wr, cfg_sel, cfg_mask, lock_wr, lock_mask, input cfg_ack, busy, cfg_err);
    modport slave (input cfg_wr, cfg_sel, cfg_mask, lock_wr, lock_mask, output cfg_ack, busy, cfg_err);
`else
    modport master (output cfg_wr, cfg_sel, cfg_mask, input cfg_ack, busy);
    modport slave (input cfg_wr, cfg_sel, cfg_mask, output cfg_ack, busy);
`endif
endinterface

// File: rtl/mux_io_sel_ctrl.sv
// mux_io_sel_ctrl: break-before-make owner of the per-pin mux_io select vector and OE gate.
// Optional sticky per-pin lock when MUX_IO_SEL_LOCK_EN is defined.
module mux_io_sel_ctrl #(
    parameter int                   GPIO_WIDTH  = 13,
    parameter int                   DEAD_CYCLES = 3,
    parameter logic [GPIO_WIDTH-1:0] RESET_SEL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_io_sel_ctrl_if.slave      cfg,
    output logic [GPIO_WIDTH-1:0] select,
    output logic [GPIO_WIDTH-1:0] oe_gate
);
    typedef enum logic [2:0] {IDLE, DRAIN, APPLY, SETTLE, DONE} state_t;
    localparam logic [7:0] CNT_DRAIN  = 8'(DEAD_CYCLES - 1);
    localparam logic [7:0] CNT_SETTLE = 8'(DEAD_CYCLES > 1 ? DEAD_CYCLES - 2 : 0);
    state_t                state, state_n;
    logic [7:0]            cnt, cnt_n;
    logic [GPIO_WIDTH-1:0] chg, chg_n, tgt, tgt_n, sel_n, gate_n, diff, req_chg;
    logic                  ack_q, ack_n, err_q, err_n, req_err;
    assign diff = (cfg.cfg_sel ^ select) & cfg.cfg_mask;
`ifdef MUX_IO_SEL_LOCK_EN
    logic [GPIO_WIDTH-1:0] lock_q;
    logic                  cfg_err_q;
    assign req_chg = diff & ~lock_q;
    assign req_err = |(diff & lock_q);
    assign cfg.cfg_err = cfg_err_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lock_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            lock_q    <= lock_q | (cfg.lock_wr ? cfg.lock_mask : '0);
            cfg_err_q <= (state == DONE) && err_q;
        end
`else
    assign req_chg = diff;
    assign req_err = 1'b0;
`endif
    assign cfg.cfg_ack = ack_q;
    assign cfg.busy    = state != IDLE;
    // Select is written on the DRAIN exit edge so the new value appears in the first settle cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        chg_n   = chg;
        tgt_n   = tgt;
        sel_n   = select;
        gate_n  = oe_gate;
        ack_n   = 1'b0;
        err_n   = err_q;
        case (state)
            IDLE: if (cfg.cfg_wr) begin
                chg_n   = req_chg;
                tgt_n   = cfg.cfg_sel & cfg.cfg_mask;
                err_n   = req_err;
                cnt_n   = |req_chg ? CNT_DRAIN : 8'd0;
                gate_n  = oe_gate & ~req_chg;
                state_n = |req_chg ? DRAIN : DONE;
            end
            DRAIN: if (cnt != 8'd0) cnt_n = cnt - 8'd1;
            else begin
                sel_n   = (select & ~chg) | (tgt & chg);
                cnt_n   = CNT_SETTLE;
                state_n = DEAD_CYCLES == 1 ? DONE : APPLY;
            end
            APPLY: begin
                cnt_n   = cnt != 8'd0 ? cnt - 8'd1 : 8'd0;
                state_n = cnt != 8'd0 ? SETTLE : DONE;
            end
            SETTLE: if (cnt != 8'd0) cnt_n = cnt - 8'd1;
            else state_n = DONE;
            DONE: begin
                gate_n  = '1;
                ack_n   = 1'b1;
                cnt_n   = 8'd0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            chg     <= '0;
            tgt     <= '0;
            select  <= RESET_SEL;
            oe_gate <= '1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            chg     <= chg_n;
            tgt     <= tgt_n;
            select  <= sel_n;
            oe_gate <= gate_n;
            ack_q   <= ack_n;
            err_q   <= err_n;
        end
endmodule
